btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer for the fetch stage. It returns a same-cycle prediction for the fetch `pc` and learns from resolved branches reported by execute. Each entry has a 2-bit saturating direction counter, and victims are chosen per set by a round-robin pointer. A multi-cycle flush sequencer clears the table on request, for example on `fence.i` or a context switch.

---
 rtl/btb_pkg.sv | 20 ++
 rtl/btb_way.sv | 63 ++++++
 rtl/btb_assoc.sv | 157 +++++++++++++++
 tb/tb_btb_assoc.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared counter encodings, flush FSM states and counter helper for the BTB
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } fsm_state_e;

  // Saturating step of the 2-bit direction counter.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    else       return (c <= CTR_WNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_way.sv
// rtl/btb_way.sv - one BTB way: SETS entries, predict and update lookup ports,
// one write port and a per-set valid clear for the flush sequencer.
module btb_way #(
  parameter int XLEN     = 32,
  parameter int SETS     = 8,
  parameter int IDX_BITS = 3,
  parameter int TAG_BITS = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] i_p_idx,
  output logic                o_p_valid,
  output logic [TAG_BITS-1:0] o_p_tag,
  output logic [XLEN-1:0]     o_p_target,
  output logic [1:0]          o_p_ctr,
  input  logic [IDX_BITS-1:0] i_u_idx,
  output logic                o_u_valid,
  output logic [TAG_BITS-1:0] o_u_tag,
  output logic [XLEN-1:0]     o_u_target,
  output logic [1:0]          o_u_ctr,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0] i_wr_tag,
  input  logic [XLEN-1:0]     i_wr_target,
  input  logic [1:0]          i_wr_ctr,
  input  logic                i_clr_en,
  input  logic [IDX_BITS-1:0] i_clr_idx
);

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [1:0]          ctr;
  } entry_t;

  logic [SETS-1:0] r_valid;
  entry_t          r_ent [SETS];

  // Only valid bits need reset; payload is ignored until its valid bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clr_en) r_valid[i_clr_idx] <= 1'b0;
      if (i_wr_en)  r_valid[i_wr_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_ent[i_wr_idx] <= '{tag: i_wr_tag, target: i_wr_target, ctr: i_wr_ctr};
  end

  assign o_p_valid  = r_valid[i_p_idx];
  assign o_p_tag    = r_ent[i_p_idx].tag;
  assign o_p_target = r_ent[i_p_idx].target;
  assign o_p_ctr    = r_ent[i_p_idx].ctr;

  assign o_u_valid  = r_valid[i_u_idx];
  assign o_u_tag    = r_ent[i_u_idx].tag;
  assign o_u_target = r_ent[i_u_idx].target;
  assign o_u_ctr    = r_ent[i_u_idx].ctr;

endmodule

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative BTB top: same-cycle prediction, resolved-branch
// learning with round-robin victims, and a one-set-per-cycle flush sequencer.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 2,
  parameter int OFFSET = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic            predict_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  input  logic            flush,
  output logic            flush_busy
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = XLEN - OFFSET - IDX_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  fsm_state_e          r_state, w_state_nxt;
  logic [IDX_BITS-1:0] r_fc, w_fc_nxt;
  logic [WAY_BITS-1:0] r_rr [SETS];

  logic [IDX_BITS-1:0] w_p_idx, w_u_idx;
  logic [TAG_BITS-1:0] w_p_tagq, w_u_tagq;
  logic                w_unused;

  logic [WAYS-1:0]     w_p_valid, w_u_valid, w_wr_en, w_p_match;
  logic [TAG_BITS-1:0] w_p_tag [WAYS];
  logic [TAG_BITS-1:0] w_u_tag [WAYS];
  logic [XLEN-1:0]     w_p_target [WAYS];
  logic [XLEN-1:0]     w_u_target [WAYS];
  logic [1:0]          w_p_ctr [WAYS];
  logic [1:0]          w_u_ctr [WAYS];

  logic                w_u_hit, w_free, w_up_act;
  logic [WAY_BITS-1:0] w_u_hit_way, w_free_way, w_alloc_way;
  logic [XLEN-1:0]     w_hit_target, w_wr_target;
  logic [1:0]          w_hit_ctr, w_wr_ctr;

  assign w_p_idx  = pc[IDX_BITS+OFFSET-1:OFFSET];
  assign w_p_tagq = pc[XLEN-1:IDX_BITS+OFFSET];
  assign w_u_idx  = update_pc[IDX_BITS+OFFSET-1:OFFSET];
  assign w_u_tagq = update_pc[XLEN-1:IDX_BITS+OFFSET];
  assign w_unused = ^{pc[OFFSET-1:0], update_pc[OFFSET-1:0]};

  assign flush_busy = (r_state == FLUSH);
  // An update coinciding with flush acceptance is dropped along with those during FLUSH.
  assign w_up_act   = update_valid && (r_state == IDLE) && !flush;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    btb_way #(.XLEN(XLEN), .SETS(SETS), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) u_way (
      .clk(clk), .rst_n(rst_n),
      .i_p_idx(w_p_idx), .o_p_valid(w_p_valid[g]), .o_p_tag(w_p_tag[g]),
      .o_p_target(w_p_target[g]), .o_p_ctr(w_p_ctr[g]),
      .i_u_idx(w_u_idx), .o_u_valid(w_u_valid[g]), .o_u_tag(w_u_tag[g]),
      .o_u_target(w_u_target[g]), .o_u_ctr(w_u_ctr[g]),
      .i_wr_en(w_wr_en[g]), .i_wr_idx(w_u_idx), .i_wr_tag(w_u_tagq),
      .i_wr_target(w_wr_target), .i_wr_ctr(w_wr_ctr),
      .i_clr_en(flush_busy), .i_clr_idx(r_fc)
    );
    assign w_p_match[g] = w_p_valid[g] && (w_p_tag[g] == w_p_tagq);
    assign w_wr_en[g]   = w_up_act && (w_u_hit ? (w_u_hit_way == WAY_BITS'(g))
                                               : (update_taken && (w_alloc_way == WAY_BITS'(g))));
  end

  always_comb begin
    predict_hit    = 1'b0;
    predict_taken  = 1'b0;
    predict_target = '0;
    if (!flush_busy) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w_p_match[w]) begin
          predict_hit    = 1'b1;
          predict_taken  = w_p_ctr[w][1];
          predict_target = w_p_target[w];
        end
      end
    end
  end

  always_comb begin
    w_u_hit      = 1'b0;
    w_u_hit_way  = '0;
    w_hit_target = '0;
    w_hit_ctr    = CTR_SNT;
    w_free       = 1'b0;
    w_free_way   = '0;
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_u_valid[w]) begin
        w_free     = 1'b1;
        w_free_way = WAY_BITS'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (w_u_valid[w] && (w_u_tag[w] == w_u_tagq)) begin
        w_u_hit      = 1'b1;
        w_u_hit_way  = WAY_BITS'(w);
        w_hit_target = w_u_target[w];
        w_hit_ctr    = w_u_ctr[w];
      end
    end
  end

  assign w_alloc_way = w_free ? w_free_way : r_rr[w_u_idx];
  assign w_wr_ctr    = w_u_hit ? ctr_next(w_hit_ctr, update_taken) : CTR_WT;
  assign w_wr_target = (w_u_hit && !update_taken) ? w_hit_target : update_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else if (flush_busy) begin
      r_rr[r_fc] <= '0;
    end else if (w_up_act && !w_u_hit && update_taken) begin
      r_rr[w_u_idx] <= (WAYS == 1) ? '0 : w_alloc_way + WAY_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fc    <= w_fc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fc_nxt    = r_fc;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_state_nxt = FLUSH;
          w_fc_nxt    = '0;
        end
      end
      FLUSH: begin
        if (r_fc == IDX_BITS'(SETS - 1)) w_state_nxt = IDLE;
        w_fc_nxt = r_fc + IDX_BITS'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - directed-vector bench for btb_assoc at default parameters
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        predict_hit, predict_taken, flush_busy;
  logic [31:0] predict_target;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic [31:0] update_target = '0;
  logic        update_taken = 1'b0;
  logic        flush = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btb_assoc #(.XLEN(32), .SETS(8), .WAYS(2), .OFFSET(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .flush(flush), .flush_busy(flush_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
    update_valid  = 1'b1;
    update_pc     = a;
    update_target = t;
    update_taken  = tk;
    tick();
    update_valid  = 1'b0;
  endtask

  task automatic pred(input string n, input logic [31:0] a, input logic h, input logic tk,
                      input logic [31:0] t);
    pc = a;
    #1;
    chk({n, ".hit"}, predict_hit, h);
    chk({n, ".taken"}, predict_taken, tk);
    chk({n, ".target"}, predict_target, t);
    chk({n, ".dup"}, $onehot0(dut.w_p_match), 1);
  endtask

  initial begin
    #1;
    pred("rst", 32'h100, 0, 0, 0);
    chk("rst.busy", flush_busy, 0);
    #10;
    rst_n = 1'b1;
    tick();

    pred("cold", 32'h100, 0, 0, 0);
    upd(32'h100, 32'h200, 1);
    pred("alloc", 32'h100, 1, 1, 32'h200);

    // 2 -> 3 saturates; taken hit refreshes target.
    upd(32'h100, 32'h200, 1);
    upd(32'h100, 32'h200, 1);
    upd(32'h100, 32'h200, 1);
    upd(32'h100, 32'h240, 1);
    pred("sat3", 32'h100, 1, 1, 32'h240);
    upd(32'h100, 32'h999, 0);
    pred("nt_to2", 32'h100, 1, 1, 32'h240);
    upd(32'h100, 32'h999, 0);
    pred("nt_to1", 32'h100, 1, 0, 32'h240);
    upd(32'h100, 32'h999, 0);
    pred("nt_to0", 32'h100, 1, 0, 32'h240);
    upd(32'h100, 32'h999, 0);
    pred("nt_sat0", 32'h100, 1, 0, 32'h240);
    upd(32'h100, 32'h240, 1);
    pred("t_to1", 32'h100, 1, 0, 32'h240);
    upd(32'h100, 32'h240, 1);
    pred("t_to2", 32'h100, 1, 1, 32'h240);

    upd(32'h104, 32'h400, 0);
    pred("nt_miss", 32'h104, 0, 0, 0);

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    upd(32'h100, 32'h1100, 1);
    upd(32'h120, 32'h1120, 1);
    pred("repl.a0", 32'h100, 1, 1, 32'h1100);
    pred("repl.a1", 32'h120, 1, 1, 32'h1120);
    upd(32'h140, 32'h1140, 1);
    pred("repl.ev0", 32'h100, 0, 0, 0);
    pred("repl.k1", 32'h120, 1, 1, 32'h1120);
    pred("repl.n2", 32'h140, 1, 1, 32'h1140);
    upd(32'h160, 32'h1160, 1);
    pred("repl.ev1", 32'h120, 0, 0, 0);
    pred("repl.k2", 32'h140, 1, 1, 32'h1140);
    pred("repl.n3", 32'h160, 1, 1, 32'h1160);

    upd(32'h104, 32'h2104, 1);
    upd(32'h10c, 32'h210c, 1);
    pred("pre_fl", 32'h10c, 1, 1, 32'h210c);
    flush         = 1'b1;
    update_valid  = 1'b1;
    update_pc     = 32'h108;
    update_target = 32'h2108;
    update_taken  = 1'b1;
    tick();
    flush         = 1'b0;
    update_valid  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fl.busy%0d", i), flush_busy, 1);
      pred($sformatf("fl.pred%0d", i), 32'h140, 0, 0, 0);
      if (i == 2) flush = 1'b1;
      if (i == 5) begin
        update_valid  = 1'b1;
        update_pc     = 32'h110;
        update_target = 32'h2110;
        update_taken  = 1'b1;
      end
      tick();
      flush        = 1'b0;
      update_valid = 1'b0;
    end
    chk("fl.done", flush_busy, 0);
    pred("fl.s0a", 32'h140, 0, 0, 0);
    pred("fl.s0b", 32'h160, 0, 0, 0);
    pred("fl.s1", 32'h104, 0, 0, 0);
    pred("fl.s3", 32'h10c, 0, 0, 0);
    pred("fl.drop", 32'h108, 0, 0, 0);
    pred("fl.dropb", 32'h110, 0, 0, 0);

    upd(32'h100, 32'h500, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("ab.busy", flush_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab.rst_busy", flush_busy, 0);
    pred("ab.rst_pred", 32'h100, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("ab.idle", flush_busy, 0);
    pred("ab.empty", 32'h100, 0, 0, 0);

    pc            = 32'h100;
    update_valid  = 1'b1;
    update_pc     = 32'h100;
    update_target = 32'h600;
    update_taken  = 1'b1;
    #1;
    chk("col.same", predict_hit, 0);
    tick();
    update_valid = 1'b0;
    pred("col.next", 32'h100, 1, 1, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
